rp_8bit_fetch_seq: RTL and testbench
====================================

// Module: rp_8bit_fetch_seq
//
// PURPOSE
// Instruction fetch sequencer for the rp_8bit AVR core. It sits between the program memory
// and the instruction decoder.
// - Issues 16-bit word fetches over a req/ack handshake.
// - Assembles one-word and two-word instructions (lds/sts/jmp/call) into a single 32-bit code.
// - Presents each instruction to the decoder over a vld/rdy handshake.
// - Executes redirects (jumps) and skips (cpse/sbrc/sbrs/sbic/sbis) requested by execute.
//
// PARAMETERS
// PAW     11  program memory word-address width; PC wraps modulo 2**PAW
// RST_PC  0   word address of the first fetch after reset
//
// PORTS
// clk       in   1    clock, all state on rising edge
// rst       in   1    synchronous reset, active high
// pmem_req  out  1    fetch request; held high until pmem_ack
// pmem_adr  out  PAW  word address; stable while pmem_req high
// pmem_rdt  in   16   read data; valid in the cycle pmem_ack is high
// pmem_ack  in   1    request completed; only meaningful while pmem_req high
// dec_vld   out  1    instruction valid toward decoder
// dec_rdy   in   1    decoder accepts; transfer when dec_vld & dec_rdy
// dec_code  out  32   [15:0] first word, [31:16] second word (0 for one-word instructions)
// dec_len   out  1    0 = one word, 1 = two words
// dec_pc    out  PAW  word address of the first word
// exe_jmp   in   1    redirect pulse (jmp/call/rjmp/ret/ijmp/irq vector)
// exe_adr   in   PAW  redirect target, sampled with exe_jmp
// exe_skp   in   1    skip pulse: drop the next complete instruction
//
// BEHAVIOUR
// Reset values: pmem_req=0, pmem_adr=RST_PC, dec_vld=0, dec_code=0, dec_len=0, dec_pc=RST_PC.
// Reset also clears internal state: skip_pend=0, jmp_pend=0.
// Two-word detect on the first word w:
//   - (w & 16'hFC0F) == 16'h9000  (lds/sts)
//   - (w & 16'hFE0C) == 16'h940C  (jmp/call)
// States:
//   RST : first cycle after reset -> W1 at pc=RST_PC.
//   W1  : pmem_req=1, adr=pc. On ack: latch w0, pc <= pc+1.
//         Two-word -> W2. Else if skip_pend -> clear skip_pend, stay W1. Else -> OUT.
//   W2  : pmem_req=1, adr=pc. On ack: latch w1, pc <= pc+1.
//         If skip_pend -> clear skip_pend, go W1. Else -> OUT.
//   OUT : dec_vld=1; code/len/pc held stable until dec_rdy. On transfer -> W1.
//         No prefetch: pmem_req=0 while in OUT.
// Throughput: best case one one-word instruction per 2 cycles with zero-wait ack
// (ack cycle, then transfer cycle).
// Redirect (exe_jmp=1 in any cycle):
//   - If no request is outstanding (OUT, RST, or req not yet issued): next cycle dec_vld=0,
//     pc <= exe_adr, state W1.
//   - If pmem_req is high and ack has not arrived: keep req/adr stable, set jmp_pend and
//     store the target. The ack's data is discarded, then W1 at the stored target.
//   - If exe_jmp coincides with pmem_ack: the data is discarded and the next cycle goes to
//     W1 at exe_adr.
//   - A redirect clears skip_pend.
//   - A second exe_jmp while jmp_pend is set overwrites the stored target.
// Skip: exe_skp sets skip_pend; the next fully assembled instruction is fetched but never
// presented.
//   - exe_skp in the same cycle as a dec transfer applies to the following instruction.
//   - exe_skp and exe_jmp in the same cycle: the jump wins and skip_pend=0.
// Simultaneous dec transfer and exe_jmp in OUT: the transfer completes, then W1 at exe_adr.
// PC arithmetic is unsigned PAW-bit and wraps: 2**PAW-1 + 1 = 0. A two-word instruction
// may straddle the wrap.
// Reset mid-operation: dropping pmem_req without ack is permitted on rst only; program
// memory must tolerate an abandoned request.
//
// STRUCTURE
// Shared package rp_8bit_pkg holds:
//   - typedef enum logic [2:0] {RST, W1, W2, OUT} fetch_st_t
//   - function automatic logic is_2word(logic [15:0] w)
//   - localparam logic [15:0] for the two match masks/values
// No sub-module; a single always_ff state/datapath process plus a comb output block.
//
// TESTING
// 1 Reset, zero-wait mem: words 0x0000, 0x0000 -> two transfers:
//   code=0x0000_0000, len=0, pc=0 then pc=1.
// 2 Word 0x940C, 0x0123 at pc 4 -> one transfer: code=0x0123_940C, len=1, pc=4;
//   next fetch adr=6.
// 3 exe_skp pulse, then 0x9100, 0x0060 (lds) at pc 8, then 0x0000 at pc 10
//   -> the lds is never shown; next dec_pc=10.
// 4 exe_jmp adr=0x200 while req pending with 3-cycle ack latency -> stale data dropped;
//   next pmem_adr=0x200; next dec_pc=0x200.
// 5 PAW=4, pc=15, 0x940E + second word at 0 -> code pair correct, len=1, pc=15,
//   next fetch adr=1.
// 6 dec_rdy=0 for 5 cycles in OUT -> dec_code/pc stable and pmem_req=0; rst mid-W2
//   -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/rp_8bit_pkg.sv
// Shared definitions for the rp_8bit core: fetch sequencer states and the
// two-word opcode detector (lds/sts, jmp/call).
package rp_8bit_pkg;

    typedef enum logic [2:0] {RST, W1, W2, OUT} fetch_st_t;

    localparam logic [15:0] LDS_STS_MASK  = 16'hFC0F;
    localparam logic [15:0] LDS_STS_VAL   = 16'h9000;
    localparam logic [15:0] JMP_CALL_MASK = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_VAL  = 16'h940C;

    function automatic logic is_2word(logic [15:0] w);
        return ((w & LDS_STS_MASK) == LDS_STS_VAL) ||
               ((w & JMP_CALL_MASK) == JMP_CALL_VAL);
    endfunction

endpackage

// File: rtl/rp_8bit_fetch_seq_if.sv
// Fetch sequencer bus bundle: program memory req/ack, decoder vld/rdy and
// execute redirect/skip pulses. master = sequencer side.
interface rp_8bit_fetch_seq_if #(
    parameter int unsigned PAW = 11
);
    logic           pmem_req;
    logic [PAW-1:0] pmem_adr;
    logic [15:0]    pmem_rdt;
    logic           pmem_ack;
    logic           dec_vld;
    logic           dec_rdy;
    logic [31:0]    dec_code;
    logic           dec_len;
    logic [PAW-1:0] dec_pc;
    logic           exe_jmp;
    logic [PAW-1:0] exe_adr;
    logic           exe_skp;

    modport master (
        output pmem_req, pmem_adr, dec_vld, dec_code, dec_len, dec_pc,
        input  pmem_rdt, pmem_ack, dec_rdy, exe_jmp, exe_adr, exe_skp
    );

    modport slave (
        input  pmem_req, pmem_adr, dec_vld, dec_code, dec_len, dec_pc,
        output pmem_rdt, pmem_ack, dec_rdy, exe_jmp, exe_adr, exe_skp
    );
endinterface

// File: rtl/rp_8bit_fetch_seq.sv
// Instruction fetch sequencer: fetches 16-bit words, assembles one/two-word
// instructions, hands them to the decoder and honours redirects and skips.
module rp_8bit_fetch_seq
    import rp_8bit_pkg::*;
#(
    parameter int unsigned    PAW    = 11,
    parameter logic [PAW-1:0] RST_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    rp_8bit_fetch_seq_if.master bus
);

    fetch_st_t      st, st_nxt;
    logic [PAW-1:0] pc, pc_nxt, pc_inc;
    logic [PAW-1:0] jmp_tgt, jmp_tgt_nxt;
    logic [PAW-1:0] dec_pc_q, dec_pc_nxt;
    logic [31:0]    code_q, code_nxt;
    logic           len_q, len_nxt;
    logic           skip_pend, skip_nxt;
    logic           jmp_pend, jmp_pend_nxt;
    logic           first_2w;

    assign pc_inc   = pc + PAW'(1);
    assign first_2w = is_2word(bus.pmem_rdt);

    assign bus.pmem_req = (st == W1) || (st == W2);
    assign bus.pmem_adr = pc;
    assign bus.dec_vld  = (st == OUT);
    assign bus.dec_code = code_q;
    assign bus.dec_len  = len_q;
    assign bus.dec_pc   = dec_pc_q;

    always_comb begin
        st_nxt       = st;
        pc_nxt       = pc;
        code_nxt     = code_q;
        len_nxt      = len_q;
        dec_pc_nxt   = dec_pc_q;
        skip_nxt     = skip_pend | bus.exe_skp;
        jmp_pend_nxt = jmp_pend;
        jmp_tgt_nxt  = jmp_tgt;

        unique case (st)
            RST: st_nxt = W1;
            W1, W2: begin
                if (bus.pmem_ack) begin
                    // A redirect seen during or before this ack makes the word stale
                    if (bus.exe_jmp || jmp_pend) begin
                        st_nxt       = W1;
                        pc_nxt       = bus.exe_jmp ? bus.exe_adr : jmp_tgt;
                        jmp_pend_nxt = 1'b0;
                    end else begin
                        pc_nxt = pc_inc;
                        if (st == W1) begin
                            code_nxt   = {16'h0000, bus.pmem_rdt};
                            len_nxt    = first_2w;
                            dec_pc_nxt = pc;
                        end else begin
                            code_nxt[31:16] = bus.pmem_rdt;
                        end
                        if ((st == W1) && first_2w) begin
                            st_nxt = W2;
                        end else if (skip_pend) begin
                            skip_nxt = bus.exe_skp;
                            st_nxt   = W1;
                        end else begin
                            st_nxt = OUT;
                        end
                    end
                end else if (bus.exe_jmp) begin
                    jmp_pend_nxt = 1'b1;
                    jmp_tgt_nxt  = bus.exe_adr;
                end
            end
            OUT: if (bus.dec_rdy) st_nxt = W1;
            default: st_nxt = RST;
        endcase

        // Nothing outstanding on the memory side: redirect takes effect at once
        if (bus.exe_jmp && ((st == RST) || (st == OUT))) begin
            st_nxt = W1;
            pc_nxt = bus.exe_adr;
        end
        if (bus.exe_jmp) skip_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= RST;
            pc        <= RST_PC;
            code_q    <= '0;
            len_q     <= 1'b0;
            dec_pc_q  <= RST_PC;
            skip_pend <= 1'b0;
            jmp_pend  <= 1'b0;
        end else begin
            st        <= st_nxt;
            pc        <= pc_nxt;
            code_q    <= code_nxt;
            len_q     <= len_nxt;
            dec_pc_q  <= dec_pc_nxt;
            skip_pend <= skip_nxt;
            jmp_pend  <= jmp_pend_nxt;
        end
    end

    // Redirect target is only meaningful while jmp_pend is set
    always_ff @(posedge clk) begin
        jmp_tgt <= jmp_tgt_nxt;
    end

endmodule

// File: tb/tb_rp_8bit_fetch_seq.sv
// Bench for rp_8bit_fetch_seq: scripted scenarios plus a randomized stream
// checked against an instruction-level walk of program memory.
module tb_rp_8bit_fetch_seq;

    typedef struct packed {
        logic [31:0] code;
        logic        len;
        logic [10:0] pc;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rp_8bit_fetch_seq_if #(.PAW(11)) ifa ();
    rp_8bit_fetch_seq_if #(.PAW(4))  ifb ();

    rp_8bit_fetch_seq #(.PAW(11), .RST_PC(11'd0)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
    rp_8bit_fetch_seq #(.PAW(4),  .RST_PC(4'd15)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

    int errors = 0;
    int checks = 0;

    logic [15:0] mem_a [2048];
    logic [15:0] mem_b [16];
    int          lat_a = 0;
    bit          rand_lat = 1'b0;
    xfer_t       q_a[$];
    xfer_t       q_b[$];
    int          ack_a[$];
    int          ack_b[$];

    // Program memory A: fixed or random wait states, garbage on non-ack cycles
    initial begin
        int  cnt;
        int  need;
        bit  busy;
        cnt  = 0;
        need = 0;
        busy = 1'b0;
        ifa.pmem_ack = 1'b0;
        ifa.pmem_rdt = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            ifa.pmem_ack = 1'b0;
            ifa.pmem_rdt = 16'($urandom);
            if (ifa.pmem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = 0;
                    need = rand_lat ? int'($urandom_range(0, 2)) : lat_a;
                end
                if (cnt >= need) begin
                    ifa.pmem_ack = 1'b1;
                    ifa.pmem_rdt = mem_a[ifa.pmem_adr];
                    ack_a.push_back(int'(ifa.pmem_adr));
                    busy = 1'b0;
                end else begin
                    cnt++;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Program memory B: zero-wait
    initial begin
        ifb.pmem_ack = 1'b0;
        ifb.pmem_rdt = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            ifb.pmem_ack = ifb.pmem_req;
            ifb.pmem_rdt = ifb.pmem_req ? mem_b[ifb.pmem_adr] : 16'($urandom);
            if (ifb.pmem_req) ack_b.push_back(int'(ifb.pmem_adr));
        end
    end

    always @(negedge clk) begin
        if (!rst && ifa.dec_vld && ifa.dec_rdy) q_a.push_back({ifa.dec_code, ifa.dec_len, ifa.dec_pc});
        if (!rst && ifb.dec_vld && ifb.dec_rdy) q_b.push_back({ifb.dec_code, ifb.dec_len, 7'd0, ifb.dec_pc});
    end

    function automatic bit two_word(logic [15:0] w);
        return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
    endfunction

    function automatic logic [15:0] rand_word();
        int          r = int'($urandom_range(0, 3));
        logic [15:0] w = 16'($urandom);
        if (r == 0) w = (w & ~16'hFC0F) | 16'h9000;
        else if (r == 1) w = (w & ~16'hFE0C) | 16'h940C;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer_a(output xfer_t x, output bit ok);
        ok = 1'b0;
        x  = '0;
        for (int i = 0; i < 300; i++) begin
            if (q_a.size() > 0) break;
            step();
        end
        if (q_a.size() > 0) begin
            x  = q_a.pop_front();
            ok = 1'b1;
        end
    endtask

    // Park the sequencer with the decoder stalled, then redirect it
    task automatic redirect_a(input logic [10:0] adr, input bit skp, input bit rdy_after);
        ifa.dec_rdy = 1'b0;
        repeat (14) step();
        q_a.delete();
        ifa.exe_adr = adr;
        ifa.exe_jmp = 1'b1;
        step();
        ifa.exe_jmp = 1'b0;
        ifa.exe_skp = skp;
        ifa.dec_rdy = rdy_after;
        if (skp) begin
            step();
            ifa.exe_skp = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (ifa.pmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", ifa.pmem_req); end
        checks++; if (ifa.pmem_adr !== 11'd0) begin errors++; $display("FAIL reset_adr got=%h want=0", ifa.pmem_adr); end
        checks++; if (ifa.dec_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b want=0", ifa.dec_vld); end
        checks++; if (ifa.dec_code !== 32'd0) begin errors++; $display("FAIL reset_code got=%h want=0", ifa.dec_code); end
        checks++; if (ifa.dec_len !== 1'b0) begin errors++; $display("FAIL reset_len got=%b want=0", ifa.dec_len); end
        checks++; if (ifa.dec_pc !== 11'd0) begin errors++; $display("FAIL reset_pc got=%h want=0", ifa.dec_pc); end
        checks++; if (ifb.pmem_adr !== 4'd15) begin errors++; $display("FAIL reset_adr_b got=%h want=f", ifb.pmem_adr); end
        checks++; if (ifb.dec_pc !== 4'd15) begin errors++; $display("FAIL reset_pc_b got=%h want=f", ifb.dec_pc); end
    endtask

    task automatic test_basic();
        xfer_t x;
        bit    ok;
        ifa.dec_rdy = 1'b1;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_xfer_a(x, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL basic_timeout idx=%0d got=none want=transfer", k); end
            else if (x.code !== 32'd0 || x.len !== 1'b0 || x.pc !== 11'(k)) begin
                errors++;
                $display("FAIL basic idx=%0d got code=%h len=%b pc=%h want code=0 len=0 pc=%h", k, x.code, x.len, x.pc, k);
            end
        end
    endtask

    task automatic test_two_word();
        xfer_t x;
        bit    ok;
        mem_a[4] = 16'h940C;
        mem_a[5] = 16'h0123;
        mem_a[6] = 16'h0000;
        redirect_a(11'd4, 1'b0, 1'b1);
        wait_xfer_a(x, ok);
        checks++;
        if (!ok || x.code !== 32'h0123_940C || x.len !== 1'b1 || x.pc !== 11'd4) begin
            errors++;
            $display("FAIL two_word got ok=%b code=%h len=%b pc=%h want code=0123940c len=1 pc=004", ok, x.code, x.len, x.pc);
        end
        checks++;
        if (ifa.pmem_req !== 1'b1 || ifa.pmem_adr !== 11'd6) begin
            errors++;
            $display("FAIL two_word_next got req=%b adr=%h want req=1 adr=006", ifa.pmem_req, ifa.pmem_adr);
        end
    endtask

    task automatic test_skip();
        xfer_t x;
        bit    ok;
        lat_a = 1;
        mem_a[8]  = 16'h9100;
        mem_a[9]  = 16'h0060;
        mem_a[10] = 16'h0000;
        mem_a[11] = 16'h0000;
        redirect_a(11'd8, 1'b1, 1'b1);
        wait_xfer_a(x, ok);
        checks++;
        if (!ok || x.pc !== 11'd10 || x.code !== 32'd0 || x.len !== 1'b0) begin
            errors++;
            $display("FAIL skip got ok=%b code=%h len=%b pc=%h want code=0 len=0 pc=00a", ok, x.code, x.len, x.pc);
        end
    endtask

    task automatic test_jmp_pending();
        xfer_t x;
        bit    ok;
        lat_a = 3;
        mem_a[11'h020] = 16'h1111;
        mem_a[11'h021] = 16'h2222;
        mem_a[11'h200] = 16'h3333;
        mem_a[11'h201] = 16'h0000;
        redirect_a(11'h020, 1'b0, 1'b1);
        ack_a.delete();
        ifa.exe_adr = 11'h200;
        ifa.exe_jmp = 1'b1;
        step();
        ifa.exe_jmp = 1'b0;
        checks++;
        if (ifa.pmem_req !== 1'b1 || ifa.pmem_adr !== 11'h020) begin
            errors++;
            $display("FAIL jmp_hold got req=%b adr=%h want req=1 adr=020", ifa.pmem_req, ifa.pmem_adr);
        end
        wait_xfer_a(x, ok);
        checks++;
        if (!ok || x.pc !== 11'h200 || x.code !== 32'h0000_3333 || x.len !== 1'b0) begin
            errors++;
            $display("FAIL jmp_xfer got ok=%b code=%h len=%b pc=%h want code=00003333 len=0 pc=200", ok, x.code, x.len, x.pc);
        end
        checks++;
        if (ack_a.size() < 2 || ack_a[0] != 32'h020 || ack_a[1] != 32'h200) begin
            errors++;
            $display("FAIL jmp_adr_seq got n=%0d first=%h second=%h want 020 then 200", ack_a.size(),
                     (ack_a.size() > 0) ? ack_a[0] : -1, (ack_a.size() > 1) ? ack_a[1] : -1);
        end
        lat_a = 0;
    endtask

    task automatic test_wrap();
        xfer_t x;
        checks++;
        if (q_b.size() == 0) begin
            errors++;
            $display("FAIL wrap_xfer got=none want=transfer");
        end else begin
            x = q_b[0];
            if (x.code !== 32'hABCD_940E || x.len !== 1'b1 || x.pc !== 11'd15) begin
                errors++;
                $display("FAIL wrap_xfer got code=%h len=%b pc=%h want code=abcd940e len=1 pc=00f", x.code, x.len, x.pc);
            end
        end
        checks++;
        if (ack_b.size() < 3 || ack_b[0] != 15 || ack_b[1] != 0 || ack_b[2] != 1) begin
            errors++;
            $display("FAIL wrap_adr_seq got n=%0d want 15,0,1", ack_b.size());
        end
    endtask

    task automatic test_random();
        xfer_t       x;
        logic [10:0] base, mpc, skip_after;
        logic [15:0] w0;
        logic [31:0] exp_code;
        bit          exp_len, skip_armed;
        int          got;
        base = 11'($urandom_range(32'h300, 32'h600));
        for (int i = 0; i < 256; i++) mem_a[base + 11'(i)] = rand_word();
        rand_lat = 1'b1;
        redirect_a(base, 1'b0, 1'b1);
        mpc = base;
        skip_armed = 1'b0;
        skip_after = '0;
        got = 0;
        for (int cyc = 0; cyc < 3000 && got < 25; cyc++) begin
            while (q_a.size() > 0 && got < 25) begin
                x = q_a.pop_front();
                w0 = mem_a[mpc];
                exp_len  = two_word(w0);
                exp_code = exp_len ? {mem_a[mpc + 11'd1], w0} : {16'h0000, w0};
                checks++;
                if (x.code !== exp_code || x.len !== exp_len || x.pc !== mpc) begin
                    errors++;
                    $display("FAIL random_stream got code=%h len=%b pc=%h want code=%h len=%b pc=%h",
                             x.code, x.len, x.pc, exp_code, exp_len, mpc);
                end
                mpc = mpc + (exp_len ? 11'd2 : 11'd1);
                if (skip_armed && x.pc == skip_after) begin
                    mpc = mpc + (two_word(mem_a[mpc]) ? 11'd2 : 11'd1);
                    skip_armed = 1'b0;
                end
                got++;
            end
            ifa.dec_rdy = ($urandom_range(0, 9) < 7);
            ifa.exe_skp = 1'b0;
            if (ifa.dec_vld && !skip_armed && $urandom_range(0, 5) == 0) begin
                ifa.exe_skp = 1'b1;
                skip_armed  = 1'b1;
                skip_after  = ifa.dec_pc;
            end
            step();
        end
        ifa.exe_skp = 1'b0;
        rand_lat = 1'b0;
        checks++;
        if (got < 25) begin errors++; $display("FAIL random_timeout got=%0d want=25", got); end
    endtask

    task automatic test_stall_and_reset();
        bit seen;
        mem_a[11'h040] = 16'h5A5A;
        mem_a[11'h041] = 16'h0000;
        redirect_a(11'h040, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (ifa.dec_vld === 1'b1) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL stall_vld got=0 want=1"); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ifa.dec_vld !== 1'b1 || ifa.dec_code !== 32'h0000_5A5A || ifa.dec_pc !== 11'h040 || ifa.pmem_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d got vld=%b code=%h pc=%h req=%b want vld=1 code=00005a5a pc=040 req=0",
                         i, ifa.dec_vld, ifa.dec_code, ifa.dec_pc, ifa.pmem_req);
            end
            step();
        end
        lat_a = 3;
        mem_a[11'h050] = 16'h940C;
        mem_a[11'h051] = 16'h1234;
        redirect_a(11'h050, 1'b0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (ifa.pmem_req === 1'b1 && ifa.pmem_adr === 11'h051) seen = 1'b1;
            else step();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mid_w2_reach got=0 want=1"); end
        rst = 1'b1;
        step();
        checks++;
        if (ifa.pmem_req !== 1'b0 || ifa.pmem_adr !== 11'd0 || ifa.dec_vld !== 1'b0 ||
            ifa.dec_code !== 32'd0 || ifa.dec_len !== 1'b0 || ifa.dec_pc !== 11'd0) begin
            errors++;
            $display("FAIL mid_w2_reset got req=%b adr=%h vld=%b code=%h len=%b pc=%h want all zero",
                     ifa.pmem_req, ifa.pmem_adr, ifa.dec_vld, ifa.dec_code, ifa.dec_len, ifa.dec_pc);
        end
        checks++;
        if (ifb.pmem_req !== 1'b0 || ifb.pmem_adr !== 4'd15 || ifb.dec_vld !== 1'b0) begin
            errors++;
            $display("FAIL mid_w2_reset_b got req=%b adr=%h vld=%b want req=0 adr=f vld=0",
                     ifb.pmem_req, ifb.pmem_adr, ifb.dec_vld);
        end
        lat_a = 0;
        rst = 1'b0;
        step();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem_a[i] = rand_word();
        mem_a[0] = 16'h0000;
        mem_a[1] = 16'h0000;
        for (int i = 0; i < 16; i++) mem_b[i] = 16'h0000;
        mem_b[15] = 16'h940E;
        mem_b[0]  = 16'hABCD;
        ifa.dec_rdy = 1'b0;
        ifa.exe_jmp = 1'b0;
        ifa.exe_adr = '0;
        ifa.exe_skp = 1'b0;
        ifb.dec_rdy = 1'b1;
        ifb.exe_jmp = 1'b0;
        ifb.exe_adr = '0;
        ifb.exe_skp = 1'b0;

        test_reset();
        test_basic();
        test_two_word();
        test_skip();
        test_jmp_pending();
        test_wrap();
        test_random();
        test_stall_and_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
